// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//   Pipelined bitwise logic unit with valid/ready handshakes on both sides.
//   Eight bitwise ops are selected per transaction. The result, its op code and
//   a zero flag are computed when stage 0 loads and ride unchanged through the
//   remaining stages. Empty stages refill immediately, so bubbles collapse
//   under backpressure and up to STAGES transactions can be buffered.
//
// Parameters
//   WIDTH  : operand/result width in bits (>= 1)
//   STAGES : pipeline depth = accept-to-output latency in cycles (>= 1)
//   CNT_W  : width of the completed-transaction counter
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : input transaction valid
//   in_ready   : unit can accept input this cycle (combinational)
//   in_op      : op select 0..7 (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS)
//   in_a/in_b  : operands (in_b ignored by NOT and PASS)
//   out_valid  : result valid
//   out_ready  : consumer accepts result this cycle
//   out_y      : result
//   out_zero   : out_y == 0
//   out_op     : op code that produced out_y
//   xfer_count : number of completed output handshakes, wraps
// -----------------------------------------------------------------------------
module logic_unit_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_zero,
  output logic [2:0]       out_op,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Everything a stage carries besides its valid bit.
  typedef struct packed {
    logic [2:0]       op;
    logic             zero;
    logic [WIDTH-1:0] y;
  } slot_t;

  // Reset image: result 0, so the zero flag reads 1.
  localparam slot_t SLOT_RST = '{op: 3'd0, zero: 1'b1, y: '0};

  slot_t              slot_q [STAGES];
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  load;
  logic [CNT_W-1:0]   xfer_q;
  logic [WIDTH-1:0]   result;
  slot_t              in_slot;

  // ---------------------------------------------------------------------------
  // Op evaluation, done once at the pipeline entry.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    result = in_a;
    case (op_e'(in_op))
      OP_NOT:  result = ~in_a;
      OP_AND:  result = in_a & in_b;
      OP_OR:   result = in_a | in_b;
      OP_XOR:  result = in_a ^ in_b;
      OP_NAND: result = ~(in_a & in_b);
      OP_NOR:  result = ~(in_a | in_b);
      OP_XNOR: result = ~(in_a ^ in_b);
      OP_PASS: result = in_a;
    endcase
    in_slot = '{op: in_op, zero: (result == '0), y: result};
  end

  // ---------------------------------------------------------------------------
  // Load enables. A stage may load when it is empty or when its content moves
  // on this cycle. Walking from the output back toward the input, a stage
  // advances exactly when the stage after it loads; the last stage advances on
  // out_ready. An empty stage anywhere breaks the chain, which is what lets
  // upstream items close a bubble while the output is stalled.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic chain;
    load  = '0;
    // NOTE: blocking assignments here model the ripple from the output back
    // to the input within one cycle; 'chain' carries the previous stage's
    // load so the vector never reads its own bits.
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = !valid_q[k] || chain;
      chain   = load[k];
    end
  end

  assign in_ready = rst_n && load[0];

  // ---------------------------------------------------------------------------
  // Stage registers and transfer counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the data registers are cleared too, not just the valid bits,
      // because the outputs must read as a clean zero result after reset.
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) slot_q[k] <= SLOT_RST;
      xfer_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every stage samples its
      // predecessor's value from before this edge.
      if (load[0]) begin
        valid_q[0] <= in_valid;
        if (in_valid) slot_q[0] <= in_slot;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= valid_q[k-1];
          // Payload only moves with a real item; a bubble leaves it alone.
          if (valid_q[k-1]) slot_q[k] <= slot_q[k-1];
        end
      end
      if (out_valid && out_ready) xfer_q <= xfer_q + CNT_W'(1);
    end
  end

  assign out_valid  = valid_q[STAGES-1];
  assign out_y      = slot_q[STAGES-1].y;
  assign out_zero   = slot_q[STAGES-1].zero;
  assign out_op     = slot_q[STAGES-1].op;
  assign xfer_count = xfer_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//   Self-checking bench for logic_unit_pipe (WIDTH=4, STAGES=3, CNT_W=3).
//   The reference model is a queue of accepted transactions. An item reaches
//   the output STAGES-1 cycles after acceptance, but never before the item
//   ahead of it has left. in_ready is high whenever fewer than STAGES items
//   are held or the consumer is ready. A compare process checks the DUT
//   against that model on every falling edge. Directed phases pin the model
//   with hand-computed literals; a randomized phase then stresses it.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;

  localparam int WIDTH  = 4;
  localparam int STAGES = 3;
  localparam int CNT_W  = 3;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic [2:0]       out_op;
  logic [CNT_W-1:0] xfer_count;

  logic_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_zero   (out_zero),
    .out_op     (out_op),
    .xfer_count (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Bitwise semantics of each op, straight from the op table.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               acc;   // edge at which the item was accepted
  } txn_t;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic [2:0]       op;
    int               xfer_at;  // edge at which the output handshake happened
  } obs_t;

  txn_t q[$];        // accepted, not yet delivered
  obs_t seen[$];     // what the DUT actually delivered
  int   n_xfer     = 0;
  int   last_leave = 0;
  bit   armed      = 0;  // model defined once a reset edge has occurred
  bit   pristine   = 0;  // no item accepted since the last reset

  // ---------------------------------------------------------------------------
  // Compare process: check state after the previous edge, then advance the
  // model to the state it must have after the coming edge.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : compare
    bit               ev;
    bit               er;
    logic [WIDTH-1:0] ey;
    txn_t             t;
    obs_t             o;

    ev = armed && (q.size() > 0) && (cyc >= imax(q[0].acc + STAGES - 1, last_leave));
    er = (q.size() < STAGES) || out_ready;

    if (armed) begin
      check("out_valid", out_valid, ev);
      if (ev) begin
        ey = ref_op(q[0].op, q[0].a, q[0].b);
        check("out_y", out_y, ey);
        check("out_zero", out_zero, (ey == '0));
        check("out_op", out_op, q[0].op);
      end else if (pristine) begin
        check("idle_y", out_y, 0);
        check("idle_zero", out_zero, 1);
        check("idle_op", out_op, 0);
      end
      check("xfer_count", xfer_count, n_xfer % (1 << CNT_W));
    end

    if (!rst_n) check("in_ready_in_reset", in_ready, 0);
    else if (armed) check("in_ready", in_ready, er);

    if (!rst_n) begin
      q.delete();
      n_xfer     = 0;
      last_leave = 0;
      armed      = 1;
      pristine   = 1;
    end else if (armed) begin
      if (ev && out_ready) begin
        o.y = out_y; o.zero = out_zero; o.op = out_op; o.xfer_at = cyc + 1;
        seen.push_back(o);
        void'(q.pop_front());
        n_xfer++;
        last_leave = cyc + 1;
      end
      if (in_valid && er) begin
        t.op = in_op; t.a = in_a; t.b = in_b; t.acc = cyc + 1;
        q.push_back(t);
        pristine = 0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic ordy, output bit acc);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = ordy;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, '0, ordy, acc);
  endtask

  task automatic pulse_reset();
    bit acc;
    rst_n = 1'b0;
    step(1'b0, 3'd0, '0, '0, 1'b1, acc);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    bit   acc;
    int   acc_edge;
    int   nacc;
    int   exp_y [9];
    logic ordy;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_xfer_count", xfer_count, 0);
    check("rst_out_zero", out_zero, 1);

    // NOT of 0 and of A, with latency measured.
    seen.delete();
    step(1'b1, 3'd0, 4'h0, 4'h0, 1'b1, acc);
    acc_edge = cyc;
    step(1'b1, 3'd0, 4'hA, 4'h0, 1'b1, acc);
    idle(STAGES + 3, 1'b1);
    check("not_count", seen.size(), 2);
    if (seen.size() >= 2) begin
      check("not0_y", seen[0].y, 4'hF);
      check("not0_zero", seen[0].zero, 0);
      check("not0_latency", seen[0].xfer_at - acc_edge, STAGES);
      check("notA_y", seen[1].y, 4'h5);
    end

    // All eight ops back-to-back, then OR of zeros.
    exp_y = '{4'h3, 4'h8, 4'hE, 4'h6, 4'h7, 4'h1, 4'h9, 4'hC, 4'h0};
    seen.delete();
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'(i), 4'hC, 4'hA, 1'b1, acc);
      nacc += int'(acc);
    end
    step(1'b1, 3'd2, 4'h0, 4'h0, 1'b1, acc);
    nacc += int'(acc);
    idle(STAGES + 3, 1'b1);
    check("ops_accepted", nacc, 9);
    check("ops_count", seen.size(), 9);
    if (seen.size() == 9) begin
      for (int i = 0; i < 9; i++) begin
        check($sformatf("ops_y[%0d]", i), seen[i].y, exp_y[i]);
        check($sformatf("ops_op[%0d]", i), seen[i].op, (i == 8) ? 2 : i);
      end
      check("or_zero_flag", seen[8].zero, 1);
      check("ops_throughput", seen[8].xfer_at - seen[0].xfer_at, 8);
    end

    // Backpressure: exactly STAGES accepted while stalled, then drain.
    pulse_reset();
    seen.delete();
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 1'b0, acc);
      nacc += int'(acc);
    end
    check("bp_accepted", nacc, STAGES);
    check("bp_in_ready_low", in_ready, 0);
    idle(STAGES + 3, 1'b1);
    check("bp_delivered", seen.size(), STAGES);
    check("bp_xfer_count", xfer_count, STAGES);

    // Bubble collapse: one item, a gap, then two more, all while stalled.
    step(1'b1, 3'd1, 4'hF, 4'h3, 1'b0, acc);
    check("bubble_acc0", acc, 1);
    idle(1, 1'b0);
    step(1'b1, 3'd2, 4'h1, 4'h4, 1'b0, acc);
    check("bubble_acc1", acc, 1);
    step(1'b1, 3'd3, 4'h6, 4'h5, 1'b0, acc);
    check("bubble_acc2", acc, 1);
    step(1'b1, 3'd7, 4'h9, 4'h0, 1'b0, acc);
    check("bubble_full", acc, 0);
    idle(STAGES + 3, 1'b1);

    // Reset with two items in flight.
    step(1'b1, 3'd7, 4'h3, 4'h0, 1'b0, acc);
    step(1'b1, 3'd7, 4'h4, 4'h0, 1'b0, acc);
    pulse_reset();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_xfer_count", xfer_count, 0);
    seen.delete();
    idle(STAGES + 3, 1'b1);
    check("midrst_no_stale", seen.size(), 0);

    // Counter wrap: nine transfers on a 3-bit counter.
    for (int i = 0; i < 9; i++) step(1'b1, 3'd7, 4'(i), 4'h0, 1'b1, acc);
    idle(STAGES + 3, 1'b1);
    check("wrap_xfer_count", xfer_count, 1);

    // Randomized traffic with bursts of backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        pulse_reset();
      end else begin
        ordy = ((i / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
        step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 4'($urandom),
             4'($urandom), ordy, acc);
      end
    end
    idle(STAGES + 3, 1'b1);
    check("final_drained", out_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
